// File: rtl/prbs_checker_if.sv
// Bit-stream and status bundle between a PRBS source/monitor and prbs_checker.
interface prbs_checker_if #(
  parameter int unsigned ERR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 en;
  logic                 prbs_in;
  logic                 clear_cnt;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_WIDTH-1:0] err_count;
  logic [CNT_WIDTH-1:0] bit_count;

  // Source side: drives the stream, observes checker status.
  modport master (
    output en, prbs_in, clear_cnt,
    input  locked, err_pulse, err_count, bit_count
  );

  // Checker side.
  modport slave (
    input  en, prbs_in, clear_cnt,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x^8+x^4+x^3+x^2+1 PRBS stream. Hunts for
// lock by predicting each bit from the received history, then free-runs on its
// own predictions and counts bit errors, dropping lock on a dense error window.
module prbs_checker #(
  parameter int unsigned LOCK_MATCHES = 16,
  parameter int unsigned WINDOW       = 64,
  parameter int unsigned LOSS_ERRS    = 8,
  parameter int unsigned ERR_WIDTH    = 16,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input logic         clk,
  input logic         rst,
  prbs_checker_if.slave bus
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e               state_q;
  logic [7:0]           hist_q;       // hist_q[0] is the newest bit
  logic [3:0]           fill_q;
  logic [7:0]           match_cnt_q;
  logic [7:0]           win_cnt_q;
  logic [7:0]           win_errs_q;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic [ERR_WIDTH-1:0] err_count_q;
  logic [CNT_WIDTH-1:0] bit_count_q;

  logic       pred;
  logic       mismatch;
  logic       hunt_match;
  logic [8:0] match_nxt;
  logic [8:0] win_nxt;
  logic [8:0] werr_nxt;

  // Prediction from s[n+8] = s[n+4]^s[n+3]^s[n+2]^s[n] and derived next values.
  always_comb begin
    pred       = hist_q[7] ^ hist_q[5] ^ hist_q[4] ^ hist_q[3];
    mismatch   = bus.prbs_in != pred;
    // An all-zero history is never a valid LFSR state, so it cannot match.
    hunt_match = !mismatch && (hist_q != 8'h00);
    match_nxt  = {1'b0, match_cnt_q} + 9'd1;
    win_nxt    = {1'b0, win_cnt_q} + 9'd1;
    werr_nxt   = {1'b0, win_errs_q} + {8'd0, mismatch};
  end

  // Lock FSM, history, loss-of-lock window and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      hist_q      <= 8'h00;
      fill_q      <= 4'd0;
      match_cnt_q <= 8'd0;
      win_cnt_q   <= 8'd0;
      win_errs_q  <= 8'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          StHunt: begin
            hist_q <= {hist_q[6:0], bus.prbs_in};
            if (fill_q < 4'd8) begin
              fill_q <= fill_q + 4'd1;
            end else if (hunt_match) begin
              if (match_nxt == 9'(LOCK_MATCHES)) begin
                state_q     <= StLocked;
                locked_q    <= 1'b1;
                match_cnt_q <= 8'd0;
                win_cnt_q   <= 8'd0;
                win_errs_q  <= 8'd0;
              end else begin
                match_cnt_q <= match_nxt[7:0];
              end
            end else begin
              match_cnt_q <= 8'd0;
            end
          end
          StLocked: begin
            // Free-run on the prediction so one line error is counted once.
            hist_q      <= {hist_q[6:0], pred};
            err_pulse_q <= mismatch;
            if (werr_nxt == 9'(LOSS_ERRS)) begin
              state_q     <= StHunt;
              locked_q    <= 1'b0;
              fill_q      <= 4'd0;
              match_cnt_q <= 8'd0;
              hist_q      <= 8'h00;
              win_cnt_q   <= 8'd0;
              win_errs_q  <= 8'd0;
            end else if (win_nxt == 9'(WINDOW)) begin
              win_cnt_q  <= 8'd0;
              win_errs_q <= 8'd0;
            end else begin
              win_cnt_q  <= win_nxt[7:0];
              win_errs_q <= werr_nxt[7:0];
            end
          end
          default: state_q <= StHunt;
        endcase
      end
      // Clear wins over a coincident increment.
      if (bus.clear_cnt) begin
        err_count_q <= '0;
        bit_count_q <= '0;
      end else if (bus.en && (state_q == StLocked)) begin
        if (bit_count_q != '1) bit_count_q <= bit_count_q + 1'b1;
        if (mismatch && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, burst loss/relock,
// saturation with clear, reset mid-lock and stuck lines.
module tb_prbs_checker;

  localparam int unsigned EW = 4;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs_checker_if #(.ERR_WIDTH(EW), .CNT_WIDTH(CW)) bus ();

  prbs_checker #(
    .LOCK_MATCHES(16),
    .WINDOW      (64),
    .LOSS_ERRS   (8),
    .ERR_WIDTH   (EW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_checks = 0;
  int         n_errs = 0;
  logic [7:0] gen_h = 8'h00;
  int         gen_n = 0;
  int         pulse_cnt = 0;
  int         stray_pulse = 0;
  int         locked_hi = 0;
  int         since_lock = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe every 4th clock; called and returns at a negedge.
  task automatic strobe(input logic b, input logic clr);
    bus.en        = 1'b1;
    bus.prbs_in   = b;
    bus.clear_cnt = clr;
    @(negedge clk);
    pulse_cnt += int'(bus.err_pulse);
    locked_hi += int'(bus.locked);
    bus.en        = 1'b0;
    bus.clear_cnt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      stray_pulse += int'(bus.err_pulse);
    end
  endtask

  // Next generator bit (eight 1s, then the recurrence), optionally inverted.
  task automatic send(input logic flip, input logic clr);
    logic b;
    b = (gen_n < 8) ? 1'b1 : (gen_h[7] ^ gen_h[5] ^ gen_h[4] ^ gen_h[3]);
    gen_h = {gen_h[6:0], b};
    gen_n++;
    since_lock++;
    strobe(b ^ flip, clr);
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0);
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.prbs_in   = 1'b0;
    bus.clear_cnt = 1'b0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_locked", {31'd0, bus.locked}, 32'd0);
    check("rst_pulse", {31'd0, bus.err_pulse}, 32'd0);
    check("rst_err", 32'(bus.err_count), 32'd0);
    check("rst_bits", bus.bit_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Error-free stream: lock after 8 fill + 16 matches.
    send_n(23);
    check("t1_not_yet", {31'd0, bus.locked}, 32'd0);
    send_n(1);
    check("t1_lock24", {31'd0, bus.locked}, 32'd1);
    since_lock = 0;
    pulse_cnt  = 0;
    send_n(255);
    check("t1_err", 32'(bus.err_count), 32'd0);
    check("t1_bits", bus.bit_count, 32'd255);
    check("t1_pulses", pulse_cnt, 0);

    // Single inverted bit.
    send(1'b1, 1'b0);
    check("t2_pulse", pulse_cnt, 1);
    check("t2_err", 32'(bus.err_count), 32'd1);
    check("t2_locked", {31'd0, bus.locked}, 32'd1);
    send_n(100);
    check("t2_after_pulses", pulse_cnt, 1);
    check("t2_after_err", 32'(bus.err_count), 32'd1);

    // Clear on a clean bit: that bit is not counted.
    send(1'b0, 1'b1);
    check("t4_clr_err", 32'(bus.err_count), 32'd0);
    check("t4_clr_bits", bus.bit_count, 32'd0);
    // Burst aligned to a fresh window.
    while (since_lock % 64 != 0) send(1'b0, 1'b0);
    pulse_cnt = 0;
    repeat (7) send(1'b1, 1'b0);
    check("t4_lock_7", {31'd0, bus.locked}, 32'd1);
    send(1'b1, 1'b0);
    check("t4_lost_8", {31'd0, bus.locked}, 32'd0);
    check("t4_pulses", pulse_cnt, 8);
    check("t4_err", 32'(bus.err_count), 32'd8);
    send_n(23);
    check("t4_relock_23", {31'd0, bus.locked}, 32'd0);
    send_n(1);
    check("t4_relock_24", {31'd0, bus.locked}, 32'd1);
    since_lock = 0;

    // Saturation of the 4-bit error counter with isolated errors.
    send(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send_n(69);
      send(1'b1, 1'b0);
      if (i == 14) check("t5_err15", 32'(bus.err_count), 32'd15);
    end
    check("t5_sat", 32'(bus.err_count), 32'd15);
    check("t5_locked", {31'd0, bus.locked}, 32'd1);
    send(1'b1, 1'b1);
    check("t5_clr_err", 32'(bus.err_count), 32'd0);
    check("t5_clr_bits", bus.bit_count, 32'd0);
    check("t5_clr_locked", {31'd0, bus.locked}, 32'd1);

    // Reset mid-lock.
    send_n(10);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0);
      send_n(5);
    end
    check("t6_err3", 32'(bus.err_count), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_locked", {31'd0, bus.locked}, 32'd0);
    check("t6_err", 32'(bus.err_count), 32'd0);
    check("t6_bits", bus.bit_count, 32'd0);
    send_n(23);
    check("t6_relock_23", {31'd0, bus.locked}, 32'd0);
    send_n(1);
    check("t6_relock_24", {31'd0, bus.locked}, 32'd1);

    // Stuck lines never lock.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    locked_hi = 0;
    repeat (1000) strobe(1'b0, 1'b0);
    repeat (1000) strobe(1'b1, 1'b0);
    check("t3_locked_seen", locked_hi, 0);
    check("t3_err", 32'(bus.err_count), 32'd0);

    check("stray_pulses", stray_pulse, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the 8-bit PRBS generator. It checks a serial bit stream produced by the Galois LFSR with taps x^8+x^4+x^3+x^2+1 (period 255).
- It self-synchronises to the incoming stream, declares lock, then free-runs a local reference generator and counts bit errors.
- The stream arrives on the same 100 MHz clock, with one bit per clock-enable strobe.
- It drives board LEDs and debug counters in the lab PRBS loopback project.

Parameters:
- LOCK_MATCHES, 16: number of consecutive correct predictions required in HUNT before declaring lock (range 1..255).
- WINDOW, 64: length of the loss-of-lock observation window, in received bits (range 2..255).
- LOSS_ERRS, 8: number of errors within one window that forces a return to HUNT (range 1..WINDOW).
- ERR_WIDTH, 16: width of the saturating error counter.
- CNT_WIDTH, 32: width of the saturating checked-bit counter.

Ports:
- clk  in  1  100 MHz master clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bit strobe; prbs_in is valid and consumed only on clock edges where en=1.
- prbs_in  in  1  received PRBS bit.
- clear_cnt  in  1  synchronous clear of err_count and bit_count; lock state is unaffected.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse flagging a mismatch in LOCKED.
- err_count  out  ERR_WIDTH  saturating count of errors seen while LOCKED.
- bit_count  out  CNT_WIDTH  saturating count of bits checked while LOCKED.

Behaviour:

Reset
- rst=1 at a clock edge sets: state=HUNT, H=8'h00, fill=0, match_cnt=0, win_cnt=0, win_errs=0.
- Outputs after reset: locked=0, err_pulse=0, err_count=0, bit_count=0.
- rst overrides every other input, including in mid-lock.

History and prediction
- History register H[7:0] holds the last 8 bits; H[0] is the newest.
- Prediction p = H[7]^H[5]^H[4]^H[3], from the recurrence s[n+8] = s[n+4]^s[n+3]^s[n+2]^s[n].
- All outputs are registered. Each takes effect on the edge where en=1 and is visible in the following cycle. No state changes on edges where en=0, and err_pulse is 0 on those cycles.

HUNT (on each en edge)
- Always shift the received bit into H: H <= {H[6:0], prbs_in}.
- While fill<8: increment fill; do not compare.
- Once fill=8, a match is prbs_in==p with H!=0. The all-zero history counts as a mismatch, so a stuck-at-0 line never locks.
- On a match: match_cnt+1. On a mismatch: match_cnt=0.
- If match_cnt reaches LOCK_MATCHES on this edge: go to LOCKED, set locked=1, clear win_cnt and win_errs.

LOCKED (on each en edge)
- Shift in the predicted bit, not the received bit: H <= {H[6:0], p}. A single line error therefore counts exactly once.
- bit_count+1.
- If prbs_in!=p: err_pulse=1, err_count+1, win_errs+1.
- win_cnt+1. When win_cnt reaches WINDOW on this edge, win_cnt and win_errs restart at 0. The current bit's error still counts toward the window that just ended.
- If win_errs+error reaches LOSS_ERRS: go to HUNT, set locked=0, clear fill, match_cnt and H. The err_pulse and count for that final bit are still issued.

Counters and clear
- err_count and bit_count saturate at all-ones and never wrap.
- clear_cnt=1 forces both to 0 on that edge. clear has priority over a coincident increment, so that bit is not counted.

Test Plan:
1. Error-free stream. Stimulus: generator seeded 8'hFF, en every 4th clk, stream starts 1,1,1,… Response: locked rises the cycle after the 24th strobe (8 fill + 16 matches). After 255 further bits, err_count=0, bit_count=255, and err_pulse never fires.
2. Single-bit error. Stimulus: after lock, invert one bit. Response: exactly one err_pulse, err_count=1, locked stays 1, and subsequent bits report no error.
3. Stuck line. Stimulus: prbs_in held at 0 for 1000 strobes, then held at 1 for 1000 strobes. Response: locked stays 0 throughout, err_count=0.
4. Error burst. Stimulus: after lock, invert 8 consecutive bits. Response: 8 err_pulses, err_count=8, locked falls the cycle after the 8th bad bit. Relock occurs after 24 clean strobes.
5. Saturation and clear. Stimulus: ERR_WIDTH=4, inject 20 isolated errors spaced more than 64 bits apart. Response: err_count=15 and holds. Then assert clear_cnt on the same edge as an error: err_count=0 next cycle, locked unaffected.
6. Reset in mid-lock. Stimulus: assert rst for one cycle while locked with err_count=3. Response: next cycle locked=0, err_count=0, bit_count=0. Relock occurs after 24 strobes.
